// File: rtl/viterbi_bit_packer.sv
// viterbi_bit_packer: packs the decoded-bit stream into W-bit words queued in a show-ahead FIFO.
// Define VITERBI_PACKER_STATS_EN to add the bits_total / words_dropped counters.
module viterbi_bit_packer #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dec_bit_valid,
    input  logic                         dec_bit,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(W+1)-1:0]       out_nbits,
    output logic                         out_last,
    output logic                         overflow,
    input  logic                         clr_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
`ifdef VITERBI_PACKER_STATS_EN
    ,output logic [31:0]                 bits_total,
    output logic [15:0]                  words_dropped
`endif
);
    localparam int CW = $clog2(W);
    localparam int NW = $clog2(W+1);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  acc, acc_nxt, bit_vec;
    logic [CW-1:0] bit_cnt, pos;
    logic [NW-1:0] cnt_nxt;
    logic          complete, push;
    logic          pend_v, pend_last;
    logic [W-1:0]  pend_data;
    logic [NW-1:0] pend_nbits;
    logic [W-1:0]  mem_data [DEPTH];
    logic [NW-1:0] mem_nbits [DEPTH];
    logic          mem_last [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, drop;

    always_comb begin
        pos          = MSB_FIRST ? CW'(W-1) - bit_cnt : bit_cnt;
        bit_vec      = '0;
        bit_vec[pos] = dec_bit_valid & dec_bit;
        acc_nxt      = acc | bit_vec;
        cnt_nxt      = NW'(bit_cnt) + NW'(dec_bit_valid);
        complete     = dec_bit_valid && bit_cnt == CW'(W-1);
        push         = complete || flush;
    end

    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign pop        = !empty && out_ready;
    // The closed word spends one cycle in the pend stage, so full/drop is judged at write time
    assign drop       = pend_v && full && !pop;
    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
    assign out_nbits  = empty ? '0 : mem_nbits[rd_ptr[AW-1:0]];
    assign out_last   = !empty && mem_last[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            bit_cnt    <= '0;
            pend_v     <= 1'b0;
            pend_data  <= '0;
            pend_nbits <= '0;
            pend_last  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            acc        <= push ? '0 : acc_nxt;
            bit_cnt    <= push ? '0 : CW'(cnt_nxt);
            pend_v     <= push;
            pend_data  <= acc_nxt;
            pend_nbits <= cnt_nxt;
            pend_last  <= flush;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (pend_v && (!full || pop)) begin
                mem_data[wr_ptr[AW-1:0]]  <= pend_data;
                mem_nbits[wr_ptr[AW-1:0]] <= pend_nbits;
                mem_last[wr_ptr[AW-1:0]]  <= pend_last;
                wr_ptr                    <= wr_ptr + 1'b1;
            end
            overflow <= drop | (overflow & ~clr_overflow);
        end
    end

`ifdef VITERBI_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_total    <= '0;
            words_dropped <= '0;
        end else begin
            if (dec_bit_valid && bits_total != '1) bits_total <= bits_total + 1'b1;
            if (drop && words_dropped != '1) words_dropped <= words_dropped + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_viterbi_bit_packer.sv
// tb_viterbi_bit_packer: table vectors, corner sequences and random traffic against a word-queue model.
module tb_viterbi_bit_packer;
    logic clk = 0, rst = 0, dec_bit_valid = 0, dec_bit = 0, flush = 0, out_ready = 1, clr_overflow = 0;
    logic out_valid, out_last, overflow, out_valid1, out_last1, overflow1;
    logic [7:0] out_data, out_data1;
    logic [3:0] out_nbits, out_nbits1;
    logic [2:0] fifo_level, fifo_level1;
`ifdef VITERBI_PACKER_STATS_EN
    logic [31:0] bt0, bt1;
    logic [15:0] wd0, wd1;
`endif

    always #5 clk = ~clk;

    viterbi_bit_packer #(.W(8), .DEPTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .dec_bit_valid(dec_bit_valid), .dec_bit(dec_bit), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_nbits(out_nbits),
        .out_last(out_last), .overflow(overflow), .clr_overflow(clr_overflow), .fifo_level(fifo_level)
`ifdef VITERBI_PACKER_STATS_EN
        , .bits_total(bt0), .words_dropped(wd0)
`endif
    );

    viterbi_bit_packer #(.W(8), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .dec_bit_valid(dec_bit_valid), .dec_bit(dec_bit), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_nbits(out_nbits1),
        .out_last(out_last1), .overflow(overflow1), .clr_overflow(clr_overflow), .fifo_level(fifo_level1)
`ifdef VITERBI_PACKER_STATS_EN
        , .bits_total(bt1), .words_dropped(wd1)
`endif
    );

    typedef struct { logic [7:0] dm, dl; int n; bit last; } word_t;
    typedef struct { bit rst, v, b, fl, ev; logic [7:0] ed, el; int en; bit elast; int elev; } vec_t;

    int total = 0, bad = 0;
    word_t mq[$];
    word_t pw;
    bit pv = 0, movf = 0;
    logic cur[$];
    logic hist[$];
    vec_t tbl[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(bit r, v, b, fl, ev, logic [7:0] ed, el, int en, bit elast, int elev);
        vec_t t;
        t.rst = r; t.v = v; t.b = b; t.fl = fl; t.ev = ev;
        t.ed = ed; t.el = el; t.en = en; t.elast = elast; t.elev = elev;
        return t;
    endfunction

    function automatic logic [7:0] wd(int k);
        logic [7:0] r = 0;
        for (int i = 0; i < 8; i++) r[7-i] = hist[8*k+i];
        return r;
    endfunction

    // Word-level reference: a bit list closed into words, one cycle in flight, then a bounded queue
    task automatic model_edge();
        bit d = 0;
        if (rst) begin
            mq.delete(); cur.delete(); pv = 0; movf = 0;
            return;
        end
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (pv) begin
            if (mq.size() < 4) mq.push_back(pw);
            else d = 1;
        end
        movf = d || (movf && !clr_overflow);
        if (dec_bit_valid) cur.push_back(dec_bit);
        pv = (cur.size() == 8) || flush;
        if (pv) begin
            pw.n = cur.size(); pw.last = flush; pw.dm = 0; pw.dl = 0;
            foreach (cur[i]) begin
                pw.dm[7-i] = cur[i];
                pw.dl[i] = cur[i];
            end
            cur.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", out_valid, mq.size() > 0);
        chk("level", fifo_level, mq.size());
        chk("overflow", overflow, movf);
        chk("level_lsb", fifo_level1, mq.size());
        if (mq.size() > 0) begin
            chk("data", out_data, mq[0].dm);
            chk("data_lsb", out_data1, mq[0].dl);
            chk("nbits", out_nbits, mq[0].n);
            chk("last", out_last, mq[0].last);
        end else begin
            chk("data_idle", out_data, 0);
            chk("nbits_idle", out_nbits, 0);
        end
    endtask

    task automatic feed(int n);
        for (int i = 0; i < n; i++) begin
            dec_bit_valid = 1; dec_bit = 1'($urandom);
            hist.push_back(dec_bit);
            step();
        end
        dec_bit_valid = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] pat;
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,1,pat[7-i],0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,8'hB2,8'h4D,8,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,8'hE0,8'h07,3,1,1));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,8'h00,8'h00,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,0));
        pat = 8'hAA;
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0,1,pat[7-i],0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,pat[0],1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,8'hAA,8'h55,8,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,0));

        foreach (tbl[k]) begin
            rst = tbl[k].rst; dec_bit_valid = tbl[k].v; dec_bit = tbl[k].b; flush = tbl[k].fl;
            step();
            chk("t_valid", out_valid, tbl[k].ev);
            chk("t_data", out_data, tbl[k].ed);
            chk("t_data_lsb", out_data1, tbl[k].el);
            chk("t_nbits", out_nbits, tbl[k].en);
            chk("t_last", out_last, tbl[k].elast);
            chk("t_level", fifo_level, tbl[k].elev);
            chk("t_ovf", overflow, 0);
        end
        rst = 0; dec_bit_valid = 0; flush = 0;

        // Stall and overflow: five words into a four-deep FIFO
        out_ready = 0; hist.delete();
        feed(40); idle(1);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", out_data, wd(0));
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", out_data, wd(k));
            step();
        end
        chk("drain_empty", out_valid, 0);

        // Push with pop while full
        clr_overflow = 1; step(); clr_overflow = 0;
        chk("ovf_clr", overflow, 0);
        out_ready = 0; hist.delete();
        feed(32); idle(1);
        chk("full4", fifo_level, 4);
        feed(8);
        out_ready = 1; step();
        chk("pp_level", fifo_level, 4);
        chk("pp_ovf", overflow, 0);
        idle(3);
        chk("pp_head5", out_data, wd(4));
        chk("pp_level1", fifo_level, 1);

        // Clear coinciding with a drop keeps overflow set
        out_ready = 0;
        feed(32);
        clr_overflow = 1; step(); clr_overflow = 0;
        chk("clr_vs_drop", overflow, 1);

        // Reset with words queued and a partial word pending
        clr_overflow = 1; step(); clr_overflow = 0;
        out_ready = 1; idle(5);
        out_ready = 0;
        feed(16); idle(1);
        chk("rst_pre_level", fifo_level, 2);
        feed(5);
        rst = 1; step(); rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        hist.delete();
        feed(8); idle(1);
        chk("rst_fresh", out_data, wd(0));
        chk("rst_fresh_n", out_nbits, 8);
        out_ready = 1; step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            dec_bit_valid = ($urandom % 4) != 0;
            dec_bit = 1'($urandom);
            flush = ($urandom % 16) == 0;
            out_ready = ($urandom % 3) != 0;
            clr_overflow = ($urandom % 32) == 0;
            rst = ($urandom % 500) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
